// File: rtl/reg_file_wb_sink_if.sv
// rtl/reg_file_wb_sink_if.sv - write-back, read-port and dump-stream bundle for the register file
interface reg_file_wb_sink_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] wb_data;
    logic              wb_write_reg;
    logic [ADDR_W-1:0] wb_add;
    logic [ADDR_W-1:0] rd_add_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_add_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_add;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    // Pipeline / bench side: drives writes, read addresses and dump control.
    modport master (
        output wb_data, wb_write_reg, wb_add,
        output rd_add_a, rd_add_b,
        output dump_start, dump_ready,
        input  rd_data_a, rd_data_b,
        input  dump_busy, dump_valid, dump_add, dump_data, dump_last
    );

    // Register file side.
    modport slave (
        input  wb_data, wb_write_reg, wb_add,
        input  rd_add_a, rd_add_b,
        input  dump_start, dump_ready,
        output rd_data_a, rd_data_b,
        output dump_busy, dump_valid, dump_add, dump_data, dump_last
    );
endinterface

// File: rtl/reg_file_wb_sink.sv
// rtl/reg_file_wb_sink.sv - MIPS register file with write-through read ports and a debug dump stream
module reg_file_wb_sink #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int DUMP_SKIP_ZERO = 0
) (
    input  logic            clk,
    input  logic            reset,
    reg_file_wb_sink_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [ADDR_W-1:0] FIRST_IDX = (DUMP_SKIP_ZERO != 0) ? ADDR_W'(1) : '0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] index;
    logic              wr_en;
    logic              in_send;
    logic              at_last;
    logic [DATA_W-1:0] dump_word;

    // A write to register 0 is dropped, so it must never feed the bypass either.
    assign wr_en = bus.wb_write_reg && (bus.wb_add != '0);

    // Register array update; register 0 is never written and stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.wb_add] <= bus.wb_data;
        end
    end

    // Read ports forward the in-flight write so ID sees it with zero latency.
    assign bus.rd_data_a = (bus.rd_add_a == '0)                   ? '0 :
                           (wr_en && (bus.rd_add_a == bus.wb_add)) ? bus.wb_data :
                                                                     regs[bus.rd_add_a];
    assign bus.rd_data_b = (bus.rd_add_b == '0)                   ? '0 :
                           (wr_en && (bus.rd_add_b == bus.wb_add)) ? bus.wb_data :
                                                                     regs[bus.rd_add_b];

    // Dump beat data uses the same bypass so a stalled beat tracks a hitting write.
    assign dump_word = (index == '0)                   ? '0 :
                       (wr_en && (index == bus.wb_add)) ? bus.wb_data :
                                                          regs[index];

    assign in_send = (state == ST_SEND);
    assign at_last = (index == {ADDR_W{1'b1}});

    // All dump outputs are forced low outside SEND, including during reset.
    assign bus.dump_busy  = in_send;
    assign bus.dump_valid = in_send;
    assign bus.dump_add   = in_send ? index : '0;
    assign bus.dump_data  = in_send ? dump_word : '0;
    assign bus.dump_last  = in_send && at_last;

    // Dump sequencer: walks the index on each accepted beat, returns to IDLE after the last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.dump_start) begin
                        state <= ST_SEND;
                        index <= FIRST_IDX;
                    end
                end
                ST_SEND: begin
                    if (bus.dump_ready) begin
                        if (at_last) begin
                            state <= ST_IDLE;
                            index <= '0;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    index <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_file_wb_sink.sv
// tb/tb_reg_file_wb_sink.sv - scoreboard bench for reg_file_wb_sink
module tb_reg_file_wb_sink;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    typedef struct packed {
        logic [AW-1:0] add;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_wb_sink_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file_wb_sink #(.DATA_W(DW), .ADDR_W(AW), .DUMP_SKIP_ZERO(0)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [DW-1:0] model [N];
    beat_t       sb [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_data      = '0;
        bus.wb_write_reg = 1'b0;
        bus.wb_add       = '0;
        bus.rd_add_a     = '0;
        bus.rd_add_b     = '0;
        bus.dump_start   = 1'b0;
        bus.dump_ready   = 1'b0;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_add       = a;
        bus.wb_data      = d;
        bus.wb_write_reg = 1'b1;
        tick();
        bus.wb_write_reg = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    task automatic fill_scoreboard();
        beat_t b;
        sb.delete();
        for (int i = 0; i < N; i++) begin
            b.add  = AW'(i);
            b.data = model[i];
            b.last = (i == N - 1);
            sb.push_back(b);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({bus.dump_busy, bus.dump_valid, bus.dump_last} !== 3'b000) begin
            bad++;
            $display("FAIL reset_dump_flags got=%b want=000", {bus.dump_busy, bus.dump_valid, bus.dump_last});
        end
        total++;
        if (bus.dump_add !== '0 || bus.dump_data !== '0) begin
            bad++;
            $display("FAIL reset_dump_bus got add=%h data=%h want 0/0", bus.dump_add, bus.dump_data);
        end
        tick();
        rst_n = 1'b1;
        bus.rd_add_a = 5'd5;
        bus.rd_add_b = 5'd31;
        @(negedge clk);
        total++;
        if (bus.rd_data_a !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd_a got=%h want=%h", bus.rd_data_a, 32'h0);
        end
        total++;
        if (bus.rd_data_b !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd_b got=%h want=%h", bus.rd_data_b, 32'h0);
        end
        tick();
    endtask

    task automatic test_write_read();
        write_reg(5'd7, 32'hDEADBEEF);
        bus.rd_add_a = 5'd7;
        bus.rd_add_b = 5'd6;
        @(negedge clk);
        total++;
        if (bus.rd_data_a !== model[7]) begin
            bad++;
            $display("FAIL wr_rd_7 got=%h want=%h", bus.rd_data_a, model[7]);
        end
        total++;
        if (bus.rd_data_b !== 32'h0) begin
            bad++;
            $display("FAIL wr_rd_6 got=%h want=%h", bus.rd_data_b, 32'h0);
        end
        tick();
    endtask

    task automatic test_reg_zero();
        bus.wb_add       = 5'd0;
        bus.wb_data      = 32'h12345678;
        bus.wb_write_reg = 1'b1;
        bus.rd_add_a     = 5'd0;
        @(negedge clk);
        total++;
        if (bus.rd_data_a !== 32'h0) begin
            bad++;
            $display("FAIL r0_same_cycle got=%h want=%h", bus.rd_data_a, 32'h0);
        end
        tick();
        bus.wb_write_reg = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rd_data_a !== 32'h0) begin
            bad++;
            $display("FAIL r0_next_cycle got=%h want=%h", bus.rd_data_a, 32'h0);
        end
        tick();
    endtask

    task automatic test_bypass();
        write_reg(5'd9, 32'h11);
        bus.wb_add       = 5'd9;
        bus.wb_data      = 32'h22;
        bus.wb_write_reg = 1'b1;
        bus.rd_add_b     = 5'd9;
        @(negedge clk);
        total++;
        if (bus.rd_data_b !== 32'h22) begin
            bad++;
            $display("FAIL bypass_same_cycle got=%h want=%h", bus.rd_data_b, 32'h22);
        end
        tick();
        model[9] = 32'h22;
        bus.wb_write_reg = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rd_data_b !== model[9]) begin
            bad++;
            $display("FAIL bypass_after_edge got=%h want=%h", bus.rd_data_b, model[9]);
        end
        tick();
        write_reg(5'd9, 32'h11);
        bus.wb_add       = 5'd9;
        bus.wb_data      = 32'h22;
        bus.wb_write_reg = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rd_data_b !== 32'h11) begin
            bad++;
            $display("FAIL no_write_no_bypass got=%h want=%h", bus.rd_data_b, 32'h11);
        end
        tick();
        @(negedge clk);
        total++;
        if (bus.rd_data_b !== model[9]) begin
            bad++;
            $display("FAIL no_write_hold got=%h want=%h", bus.rd_data_b, model[9]);
        end
        tick();
        bus.wb_data = '0;
    endtask

    task automatic test_dump_backpressure();
        beat_t         exp;
        logic          prev_stall = 1'b0;
        logic [AW-1:0] prev_add   = '0;
        logic [DW-1:0] prev_data  = '0;
        logic          done       = 1'b0;
        logic          finished   = 1'b0;
        int            beats      = 0;
        for (int i = 1; i < N; i++) write_reg(AW'(i), 32'h100 + i);
        fill_scoreboard();
        @(negedge clk);
        total++;
        if (bus.dump_valid !== 1'b0 || bus.dump_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_before_dump got valid=%b busy=%b want 0/0", bus.dump_valid, bus.dump_busy);
        end
        tick();
        bus.dump_start = 1'b1;
        bus.dump_ready = 1'b0;
        tick();
        bus.dump_start = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            bus.dump_ready = ((cyc % 2) == 1);
            bus.dump_start = (cyc == 5);
            @(negedge clk);
            if (done) begin
                total++;
                if (bus.dump_busy !== 1'b0 || bus.dump_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_after_last got busy=%b valid=%b want 0/0", bus.dump_busy, bus.dump_valid);
                end
                finished = 1'b1;
            end else if (bus.dump_valid !== 1'b1 || bus.dump_busy !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL dump_active got valid=%b busy=%b want 1/1", bus.dump_valid, bus.dump_busy);
            end else begin
                if (prev_stall) begin
                    total++;
                    if (bus.dump_add !== prev_add || bus.dump_data !== prev_data) begin
                        bad++;
                        $display("FAIL beat_hold got add=%h data=%h want add=%h data=%h",
                                 bus.dump_add, bus.dump_data, prev_add, prev_data);
                    end
                end
                if (bus.dump_ready) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL extra_beat got add=%h want none", bus.dump_add);
                    end else begin
                        exp = sb.pop_front();
                        if (bus.dump_add !== exp.add || bus.dump_data !== exp.data || bus.dump_last !== exp.last) begin
                            bad++;
                            $display("FAIL dump_beat got add=%h data=%h last=%b want add=%h data=%h last=%b",
                                     bus.dump_add, bus.dump_data, bus.dump_last, exp.add, exp.data, exp.last);
                        end
                    end
                    beats++;
                    if (bus.dump_last) done = 1'b1;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_add   = bus.dump_add;
                    prev_data  = bus.dump_data;
                end
            end
            tick();
        end
        bus.dump_ready = 1'b0;
        bus.dump_start = 1'b0;
        total++;
        if (!finished || beats != N || sb.size() != 0) begin
            bad++;
            $display("FAIL dump_count got beats=%0d left=%0d finished=%b want beats=%0d left=0 finished=1",
                     beats, sb.size(), finished, N);
        end
    endtask

    task automatic test_reset_mid_dump();
        beat_t exp;
        logic  hit10 = 1'b0;
        int    beats = 0;
        int    cycles = 0;
        logic  got_last = 1'b0;
        fill_scoreboard();
        bus.dump_start = 1'b1;
        bus.dump_ready = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        for (int cyc = 0; cyc < 100 && !hit10; cyc++) begin
            @(negedge clk);
            if (bus.dump_valid && sb.size() != 0) begin
                exp = sb.pop_front();
                total++;
                if (bus.dump_add !== exp.add || bus.dump_data !== exp.data) begin
                    bad++;
                    $display("FAIL pre_reset_beat got add=%h data=%h want add=%h data=%h",
                             bus.dump_add, bus.dump_data, exp.add, exp.data);
                end
                if (exp.add == 5'd10) hit10 = 1'b1;
            end
            if (!hit10) tick();
        end
        total++;
        if (!hit10) begin
            bad++;
            $display("FAIL reach_beat10 got=0 want=1");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.rd_add_a = 5'd5;
        for (int i = 0; i < N; i++) model[i] = '0;
        #1;
        total++;
        if ({bus.dump_busy, bus.dump_valid, bus.dump_last} !== 3'b000 || bus.dump_add !== '0 || bus.dump_data !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got busy=%b valid=%b last=%b add=%h data=%h want all 0",
                     bus.dump_busy, bus.dump_valid, bus.dump_last, bus.dump_add, bus.dump_data);
        end
        total++;
        if (bus.rd_data_a !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_cleared got=%h want=%h", bus.rd_data_a, 32'h0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        fill_scoreboard();
        bus.dump_start = 1'b1;
        bus.dump_ready = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        for (int cyc = 0; cyc < 100 && !got_last; cyc++) begin
            @(negedge clk);
            cycles++;
            if (bus.dump_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL post_reset_extra got add=%h want none", bus.dump_add);
                end else begin
                    exp = sb.pop_front();
                    if (bus.dump_add !== exp.add || bus.dump_data !== exp.data || bus.dump_last !== exp.last) begin
                        bad++;
                        $display("FAIL post_reset_beat got add=%h data=%h last=%b want add=%h data=%h last=%b",
                                 bus.dump_add, bus.dump_data, bus.dump_last, exp.add, exp.data, exp.last);
                    end
                end
                beats++;
                if (bus.dump_last) got_last = 1'b1;
            end
            tick();
        end
        bus.dump_ready = 1'b0;
        total++;
        if (!got_last || beats != N || cycles != N) begin
            bad++;
            $display("FAIL post_reset_length got beats=%0d cycles=%0d last=%b want %0d/%0d/1",
                     beats, cycles, got_last, N, N);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reg_zero();
        test_bypass();
        test_dump_backpressure();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_wb_sink.md
Name: reg_file_wb_sink

Overview:
- MIPS general-purpose register file. It is the consumer of the write-back pipeline register's outputs (data, write_reg, add).
- Provides two combinational ID-stage read ports with write-through bypass, so a value written in the same cycle is visible immediately.
- Provides a sequential debug dump engine that streams all registers out over a valid/ready handshake, for bench and board inspection.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width. Depth is 2**ADDR_W.
- DUMP_SKIP_ZERO, 0, when 1 the dump starts at register 1 instead of register 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_data  input  DATA_W  write data, from write-back stage data.
- wb_write_reg  input  1  write enable, from write-back stage write_reg.
- wb_add  input  ADDR_W  write address, from write-back stage add.
- rd_add_a  input  ADDR_W  read port A address.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_add_b  input  ADDR_W  read port B address.
- rd_data_b  output  DATA_W  read port B data (combinational).
- dump_start  input  1  single-cycle request to begin a dump.
- dump_busy  output  1  high while a dump is in progress.
- dump_valid  output  1  dump beat valid.
- dump_ready  input  1  consumer accepts the current beat.
- dump_add  output  ADDR_W  register index of the current beat.
- dump_data  output  DATA_W  register value of the current beat.
- dump_last  output  1  asserted with the final beat.

Behaviour:
- Reset (reset==0, asynchronous): all registers cleared to 0. Dump FSM goes to IDLE. dump_busy=0, dump_valid=0, dump_add=0, dump_data=0, dump_last=0. A reset mid-dump aborts the dump with no further beats.
- Write: on the rising clk edge, if wb_write_reg==1 and wb_add!=0, then reg[wb_add] <= wb_data. Writes to register 0 are discarded.
- Read of register 0: always returns 0 on both ports.
- Read bypass: if wb_write_reg==1, wb_add!=0 and rd_add_x==wb_add, then rd_data_x = wb_data in the same cycle. Otherwise rd_data_x = reg[rd_add_x].
- Read ports are purely combinational; read latency is 0 cycles.
- Dump FSM states:
  - IDLE: all dump outputs low. On dump_start==1, load index = (DUMP_SKIP_ZERO ? 1 : 0) and go to SEND.
  - SEND: dump_valid=1, dump_busy=1, dump_add=index, dump_data=reg[index] (with the same write bypass as the read ports). dump_last=1 when index==2**ADDR_W-1.
    - dump_valid==1 && dump_ready==1 with dump_last==0: index increments.
    - dump_valid==1 && dump_ready==1 with dump_last==1: go to IDLE.
    - dump_ready==0: the beat is held stable in index and dump_add. dump_data may change only if a write hits the displayed index.
- The index counter never wraps. dump_start is ignored while not in IDLE.
- The dump never stalls or blocks normal writes or reads.
- In IDLE, dump_busy=0 and dump_valid=0. A dump of N registers takes exactly N cycles when ready is held high.

Test Plan:
- Reset then read: assert reset=0 for 2 cycles and release. Read ports A=5 and B=31 -> 0x00000000, 0x00000000.
- Write and read back: write 0xDEADBEEF to register 7 with wb_write_reg=1. Next cycle, rd_add_a=7 -> 0xDEADBEEF. Read of register 6 -> 0.
- Register 0 protection: write 0x12345678 to register 0. In the same cycle and the next, rd_add_a=0 -> 0x00000000. Bypass must not fire.
- Same-cycle bypass: register 9 holds 0x11. Drive wb_add=9, wb_data=0x22, wb_write_reg=1 with rd_add_b=9 -> rd_data_b=0x22 in the same cycle, and 0x22 after the edge. With wb_write_reg=0 instead -> 0x11.
- Dump with backpressure: registers 1..31 preloaded with value = 0x100 + index, DUMP_SKIP_ZERO=0. Pulse dump_start and toggle dump_ready every other cycle.
  - Expect 32 beats, add 0..31, data 0, 0x101..0x11F.
  - dump_last only on add=31.
  - Beats held stable while ready is low.
  - dump_busy falls the cycle after the final accept.
- Reset mid-dump: start a dump and pull reset low after beat 10 -> outputs zero immediately, registers cleared. After release, a new dump starts from 0 and returns all-zero data.
